// File: rtl/prg_loader.sv
// prg_loader
//   Streams a Commodore .PRG image from the SPI slave byte stream into system
//   RAM port A. The first two stream bytes are the little-endian load address;
//   every following byte is payload written to consecutive RAM addresses.
//   The 6502 is held (cpu_hold) for the whole load plus a short tail.
//
// Optional build macro: PRG_BASIC_FIXUP_EN
//   When defined, a successful load finishes by writing end_addr into the
//   BASIC pointers VARTAB/ARYTAB/STREND ($2D..$32) before releasing the CPU.
//
// Ports:
//   clk        system clock (clk25 domain)
//   reset_n    asynchronous active-low reset
//   start      pulse, arms a new load (ignored while busy, loses to abort)
//   abort      pulse, ends the current load with error
//   s_valid    stream byte valid
//   s_data     stream byte
//   s_last     marks the final byte of the file
//   s_ready    loader accepts s_data this cycle (depends on state only)
//   ram_we     RAM write strobe, one cycle per byte
//   ram_addr   RAM write address
//   ram_din    RAM write data
//   cpu_hold   stalls the CPU and gives RAM port A to the loader
//   busy       load in progress
//   done       last load completed without error
//   error      last load had an error
//   byte_count payload bytes accepted in the current load (saturating)
//   end_addr   last written address + 1
module prg_loader #(
  parameter logic [15:0] MAX_ADDR  = 16'h7FFF,
  parameter int          HOLD_TAIL = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] byte_count,
  output logic [15:0] end_addr
);

  localparam int TW = (HOLD_TAIL > 1) ? $clog2(HOLD_TAIL) : 1;
  localparam logic [TW-1:0] TAIL_LAST = TW'(HOLD_TAIL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_LO,
    S_ADDR_HI,
    S_DATA,
`ifdef PRG_BASIC_FIXUP_EN
    S_FIXUP,
`endif
    S_TAIL
  } state_t;

  state_t        state, next_state;
  logic [15:0]   ptr;
  logic          wrapped;
  logic [TW-1:0] tail_cnt;
  logic          xfer;
  logic          writable;
`ifdef PRG_BASIC_FIXUP_EN
  logic [2:0]    fix_idx;
`endif

  assign xfer     = s_valid && s_ready;
  // Once the pointer has wrapped past $FFFF nothing more may be written.
  assign writable = !wrapped && (int'(ptr) <= int'(MAX_ADDR));
  assign cpu_hold = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) next_state = S_ADDR_LO;
      end
      S_ADDR_LO: begin
        s_ready = 1'b1;
        if (abort)     next_state = S_TAIL;
        else if (xfer) next_state = s_last ? S_TAIL : S_ADDR_HI;
      end
      S_ADDR_HI: begin
        s_ready = 1'b1;
        if (abort)     next_state = S_TAIL;
        else if (xfer) next_state = s_last ? S_TAIL : S_DATA;
      end
      S_DATA: begin
        s_ready = 1'b1;
        if (abort) next_state = S_TAIL;
        else if (xfer && s_last) begin
`ifdef PRG_BASIC_FIXUP_EN
          // A load that already failed must not corrupt the BASIC pointers.
          next_state = (error || !writable) ? S_TAIL : S_FIXUP;
`else
          next_state = S_TAIL;
`endif
        end
      end
`ifdef PRG_BASIC_FIXUP_EN
      S_FIXUP: begin
        if (abort || fix_idx == 3'd5) next_state = S_TAIL;
      end
`endif
      S_TAIL: begin
        if (tail_cnt == TAIL_LAST) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: the RAM write is registered so it lands exactly one clock after
  // the byte is accepted; ram_we defaults low so every write is a single pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_we     <= 1'b0;
      ram_addr   <= 16'h0000;
      ram_din    <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      byte_count <= 16'h0000;
      end_addr   <= 16'h0000;
      ptr        <= 16'h0000;
      wrapped    <= 1'b0;
      tail_cnt   <= '0;
`ifdef PRG_BASIC_FIXUP_EN
      fix_idx    <= 3'd0;
`endif
    end else begin
      ram_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            byte_count <= 16'h0000;
            ptr        <= 16'h0000;
            wrapped    <= 1'b0;
            tail_cnt   <= '0;
`ifdef PRG_BASIC_FIXUP_EN
            fix_idx    <= 3'd0;
`endif
          end
        end
        S_ADDR_LO: begin
          if (abort) error <= 1'b1;
          else if (xfer) begin
            ptr[7:0] <= s_data;
            if (s_last) error <= 1'b1;
          end
        end
        S_ADDR_HI: begin
          if (abort) error <= 1'b1;
          else if (xfer) begin
            ptr[15:8] <= s_data;
            end_addr  <= {s_data, ptr[7:0]};
            if (s_last) error <= 1'b1;
          end
        end
        S_DATA: begin
          if (abort) error <= 1'b1;
          else if (xfer) begin
            if (writable) begin
              ram_we   <= 1'b1;
              ram_addr <= ptr;
              ram_din  <= s_data;
              end_addr <= ptr + 16'd1;
            end else begin
              error <= 1'b1;
            end
            if (ptr == 16'hFFFF) wrapped <= 1'b1;
            ptr <= ptr + 16'd1;
            if (byte_count != 16'hFFFF) byte_count <= byte_count + 16'd1;
          end
        end
`ifdef PRG_BASIC_FIXUP_EN
        S_FIXUP: begin
          if (abort) error <= 1'b1;
          else begin
            // Even index = low byte, odd index = high byte, pairs at $2D/$2F/$31.
            ram_we   <= 1'b1;
            ram_addr <= 16'h002D + 16'(fix_idx);
            ram_din  <= fix_idx[0] ? end_addr[15:8] : end_addr[7:0];
            fix_idx  <= fix_idx + 3'd1;
          end
        end
`endif
        S_TAIL: begin
          if (abort) error <= 1'b1;
          if (tail_cnt == TAIL_LAST) begin
            tail_cnt <= '0;
            busy     <= 1'b0;
            done     <= !(error || abort);
          end else begin
            tail_cnt <= tail_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/prg_loader.md
Name: prg_loader

Overview:
- Streams a Commodore .PRG image, byte by byte, from the ESP32 SPI slave path into the 64K system RAM port A.
- Byte stream format: 2-byte little-endian load address, then payload.
- Holds the 6502 while loading, so it replaces the raw R_cpu_control[1] RAM-poke path.
- Sits between the SPI slave (upstream) and the dpram / CPU-hold logic in the top level (downstream).

Parameters:
- MAX_ADDR, 16'h7FFF: highest writable RAM address. Payload bytes above it are consumed but not written.
- HOLD_TAIL, 8: clocks cpu_hold stays high after the final RAM write, before release.

Ports:
- clk, input, 1: system clock (clk25 domain).
- reset_n, input, 1: asynchronous active-low reset.
- start, input, 1: single-cycle pulse; arms a new load.
- abort, input, 1: single-cycle pulse; ends the load immediately.
- s_valid, input, 1: stream byte valid.
- s_data, input, 8: stream byte.
- s_last, input, 1: qualifies the final byte of the file.
- s_ready, output, 1: block accepts s_data this cycle.
- ram_we, output, 1: RAM write strobe, one cycle per byte.
- ram_addr, output, 16: RAM write address.
- ram_din, output, 8: RAM write data.
- cpu_hold, output, 1: stalls CPU clock enable / muxes RAM port A to the loader.
- busy, output, 1: load in progress.
- done, output, 1: last load completed without error (level).
- error, output, 1: last load had an error (level).
- byte_count, output, 16: payload bytes accepted in the current load.
- end_addr, output, 16: last written address + 1.

Behaviour:
- Reset: all outputs 0; state IDLE; internal pointer 0.
- Transfer rule: a byte transfers when s_valid && s_ready. s_ready is combinational from state only (ADDR_LO, ADDR_HI, DATA); it never depends on s_valid.
- IDLE:
  - s_ready=0; cpu_hold=0.
  - start -> ADDR_LO. On entry: clear done, error, byte_count; set busy and cpu_hold.
  - start is ignored while busy.
- ADDR_LO:
  - On transfer, latch ptr[7:0] -> ADDR_HI.
  - s_last on this byte -> error=1 -> TAIL.
- ADDR_HI:
  - On transfer, latch ptr[15:8] -> DATA.
  - s_last on this byte -> error=1 -> TAIL.
  - end_addr = ptr.
- DATA, on each transfer:
  - If ptr <= MAX_ADDR and no wrap has occurred: next cycle ram_we=1, ram_addr=ptr, ram_din=byte.
  - Otherwise: no write, error=1.
  - Increment ptr and byte_count.
  - Write latency: exactly 1 clock after acceptance; back-to-back bytes give back-to-back writes.
  - Wrap: ptr going $FFFF -> $0000 sets a sticky wrap flag; later bytes are never written; error=1.
  - end_addr updates with each written byte to (written address + 1), mod 2^16.
  - s_last on a transfer -> FIXUP if the macro is enabled, else TAIL.
- FIXUP: see Optional Feature.
- TAIL:
  - s_ready=0; cpu_hold held for HOLD_TAIL clocks.
  - Then -> IDLE with busy=0, and done=!error.
- abort in any non-IDLE state:
  - error=1 -> TAIL.
  - A write already registered for the next cycle still completes.
  - start in the same cycle as abort: abort wins.
- byte_count saturates at 16'hFFFF.
- Async reset mid-load: everything clears instantly; cpu_hold drops; no further writes.

Optional Feature:
- Macro: PRG_BASIC_FIXUP_EN.
- Enabled: FIXUP state writes end_addr to the BASIC pointers VARTAB/ARYTAB/STREND, then -> TAIL.
  - Six consecutive ram_we cycles, s_ready=0 throughout.
  - Order: $2D=lo, $2E=hi, $2F=lo, $30=hi, $31=lo, $32=hi.
  - FIXUP is skipped if error=1.
  - abort during FIXUP stops the remaining writes.
- Disabled: no FIXUP state; DATA goes directly to TAIL.

Test Plan:
- Basic load with back-to-back valid:
  - Stimulus: start, then stream 01 12 A9 00 60 (last on 60).
  - Required: writes $1201=A9, $1202=00, $1203=60, on consecutive cycles, each 1 clk after acceptance.
  - Required: byte_count=3; end_addr=$1204; done=1 after HOLD_TAIL; cpu_hold low afterwards.
- BASIC fixup:
  - Stimulus: same stream with PRG_BASIC_FIXUP_EN defined.
  - Required: extra writes $2D=04, $2E=12, $2F=04, $30=12, $31=04, $32=12, then done=1.
- MAX_ADDR limit:
  - Stimulus: load at $7FFE with 4 bytes.
  - Required: only $7FFE and $7FFF written; byte_count=4; error=1; done=0.
- Wrap:
  - Stimulus: MAX_ADDR overridden to $FFFF; load at $FFFF with 2 bytes.
  - Required: $FFFF written, $0000 not written; error=1.
- Short file:
  - Stimulus: s_last on the first header byte.
  - Required: no ram_we; error=1; busy falls after HOLD_TAIL.
- Abort and reset:
  - Stimulus: abort after the 2nd payload byte with s_valid held high.
  - Required: no further writes; s_ready=0 next cycle; error=1.
  - Stimulus: async reset_n=0 mid-stream.
  - Required: outputs go to 0 the same cycle; start is then accepted normally.
